ahbl_sram_ws: RTL and testbench
===============================

# ahbl_sram_ws

AHB-Lite slave wrapping a single-port on-chip SRAM. It generalises the fixed 32-bit AHB SRAM slave with:
- parametrised data width, depth and read wait states;
- byte/halfword/word (and doubleword) write strobes;
- a two-cycle ERROR response for out-of-range or illegal transfers;
- deterministic write-then-read hazard stalls.

It sits on the processor's AHB-Lite bus matrix as a memory slave, alongside the existing SRAM slaves.

## Interface
Parameters:
- AHB_AWIDTH, 32, HADDR width.
- AHB_DWIDTH, 32, data width; legal values 32 or 64.
- DEPTH, 32768, number of AHB_DWIDTH-bit words; power of two.
- WAIT_STATES, 0, extra read wait cycles; range 0..3.

Ports:
- HCLK  in  1  clock; all logic on the rising edge.
- HRESETN  in  1  reset; synchronous, active-low.
- HSEL  in  1  slave select.
- HREADYIN  in  1  bus ready; an address phase is accepted only when it is 1.
- HADDR  in  AHB_AWIDTH  byte address.
- HTRANS  in  2  transfer type (IDLE/BUSY/NONSEQ/SEQ).
- HSIZE  in  3  transfer size.
- HBURST  in  3  burst type; ignored, each beat is handled independently.
- HWRITE  in  1  1 = write.
- HWDATA  in  AHB_DWIDTH  write data, valid in the data phase.
- HRDATA  out  AHB_DWIDTH  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  2  2'b00 OKAY, 2'b01 ERROR.

## Operation
Address decode:
- A transfer is accepted when HSEL & HREADYIN & HTRANS[1].
- BL = log2(AHB_DWIDTH/8). Word index = HADDR[BL+log2(DEPTH)-1:BL].
- The transfer is out-of-range if any HADDR bit above the word index is 1.
- The transfer is illegal if HSIZE > BL, or if HADDR is misaligned for HSIZE.
- Out-of-range and illegal transfers get ERROR. The RAM is not accessed.

Byte strobes:
- Little-endian. Lanes enabled = 2^HSIZE bytes starting at HADDR[BL-1:0].
- Unselected RAM bytes are preserved.

Writes:
- Address, strobes and the write flag are registered in the address phase.
- The RAM write happens at the end of the data phase with HWDATA.
- Writes are always zero-wait: HREADYOUT=1.

Reads:
- In the normal case the RAM read is issued at the end of the address phase.
- Data is returned after WAIT_STATES wait cycles.

Hazard:
- If a read's address phase coincides with a previous write's data phase, the RAM port is busy. The read address is then registered and the RAM read is issued one cycle later, adding one wait state.
- No forwarding is needed: the read always observes the completed write.

IDLE/BUSY or unselected cycles: OKAY, HREADYOUT=1, no RAM access.

HRDATA: driven from the RAM output while a read data phase is active; holds its last value otherwise.

FSM states:
- IDLE: no data phase, or a zero-wait data phase.
  - Accepted legal read with WAIT_STATES>0 or a pending hazard → RWAIT.
  - Accepted illegal/out-of-range transfer → ERR1.
- RWAIT: HREADYOUT=0 while the wait counter is nonzero; the counter decrements each cycle. At 0, HREADYOUT=1 → IDLE, or → the next state if a new transfer is accepted on that cycle.
- ERR1: HREADYOUT=0, HRESP=01 → ERR2.
- ERR2: HREADYOUT=1, HRESP=01. Any transfer accepted this cycle is decoded normally.

## Timing
- Reset values: HREADYOUT=1, HRESP=2'b00, HRDATA=0, FSM=IDLE, wait counter=0. Any registered write is discarded.
- Reset asserted mid-transfer: the next cycle shows the reset values, and no RAM write occurs on the reset cycle.
- Read latency from the address-phase edge to the HREADYOUT=1 data cycle: 1+WAIT_STATES cycles, plus 1 cycle on a write-then-read hazard.
- Back-to-back zero-wait reads sustain one beat per cycle.
- Back-to-back writes sustain one beat per cycle.
- The ERROR response always takes exactly 2 data-phase cycles. HRESP=01 is held across both cycles.
- An error transfer issued immediately after a write does not stall; the write still commits.

## Structure
- Shared package ahbl_pkg:
  - HTRANS encodings;
  - HRESP_OKAY / HRESP_ERROR;
  - FSM state typedef (IDLE, RWAIT, ERR1, ERR2);
  - a function mapping HSIZE and address LSBs to a byte-strobe vector.
- Sub-module sram_bank(DWIDTH, DEPTH):
  - single-port RAM with byte-enable write and a registered read (1-cycle);
  - inferred, with no reset on the storage array.

## Test plan
- WAIT_STATES=0, DWIDTH=32: write 0xDEADBEEF to 0x10, then read 0x10 on the next beat → the read gets 1 hazard wait, then HRDATA=0xDEADBEEF with OKAY.
- Byte writes: after a word write of 0x00000000, write byte 0xAA at 0x13 and halfword 0x5566 at 0x10 → reading 0x10 returns 0xAA005566.
- WAIT_STATES=2, back-to-back reads of 0x0 and 0x4 → each read data phase has HREADYOUT low for exactly 2 cycles; data arrives in order.
- Out-of-range: with DEPTH=1024 and DWIDTH=32, read 0x1000 → 2-cycle ERROR (01 with HREADYOUT 0, then 01 with HREADYOUT 1); the RAM is unchanged. An immediately following read of 0x0 completes OKAY.
- Illegal transfers: halfword write at 0x1 → ERROR and no write; with DWIDTH=64, HSIZE=3 at 0x8 → OKAY doubleword write.
- Reset mid-transfer: assert HRESETN low during a write data phase → RAM location unchanged, outputs at reset values on the next cycle.

Source files
------------

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions for the SRAM slave: transfer/response encodings,
// slave FSM states and byte-lane helpers.
// Ports: none (package).
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {IDLE, RWAIT, ERR1, ERR2} ahb_state_e;

  // Little-endian lane enables: 2^size bytes starting at byte offset lsb.
  // Always 8 lanes wide; a 32-bit slave uses the low four.
  function automatic logic [7:0] byte_strobe(input logic [2:0] size,
                                             input logic [2:0] lsb);
    logic [7:0] base;
    case (size)
      3'd0:    base = 8'h01;
      3'd1:    base = 8'h03;
      3'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lsb;
  endfunction

  // Address bits that must be zero for a naturally aligned transfer of this size.
  function automatic logic [2:0] align_mask(input logic [2:0] size);
    logic [2:0] m;
    case (size)
      3'd0:    m = 3'b000;
      3'd1:    m = 3'b001;
      3'd2:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sram_bank.sv
// Single-port SRAM, byte-enable write, registered (1-cycle) read; storage not reset.
// Ports: clk_i; en_i/we_i select a read or write this cycle; be_i byte lanes;
//        addr_i word index; wdata_i write data; rdata_o holds the last read word.
module sram_bank #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH),
  localparam int NB    = DWIDTH / 8
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [NB-1:0]     be_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < NB; b++) begin
          if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ahbl_sram_ws.sv
// AHB-Lite SRAM slave with byte strobes, read wait states, 2-cycle ERROR
// response and a one-cycle stall when a read's address phase meets a write's data phase.
// Ports: HCLK/HRESETN (sync, active-low); AHB-Lite slave inputs HSEL, HREADYIN,
//        HADDR, HTRANS, HSIZE, HBURST (unused), HWRITE, HWDATA; outputs HRDATA, HREADYOUT, HRESP.
module ahbl_sram_ws
  import ahbl_pkg::*;
#(
  parameter int AHB_AWIDTH  = 32,
  parameter int AHB_DWIDTH  = 32,
  parameter int DEPTH       = 32768,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  HSEL,
  input  logic                  HREADYIN,
  input  logic [AHB_AWIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic                  HWRITE,
  input  logic [AHB_DWIDTH-1:0] HWDATA,
  output logic [AHB_DWIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP
);

  localparam int         NB       = AHB_DWIDTH / 8;
  localparam int         BL       = $clog2(NB);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [2:0] LSB_MASK = 3'(NB - 1);

  ahb_state_e            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  wr_pend_q, wr_pend_d;
  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic [NB-1:0]         wr_strb_q, wr_strb_d;
  logic                  rd_hz_q, rd_hz_d;     // hazard-deferred read to issue this cycle
  logic [AW-1:0]         rd_addr_q, rd_addr_d;
  logic                  rd_dph_q, rd_dph_d;   // a read data phase is in progress
  logic [AHB_DWIDTH-1:0] hold_q;

  logic                  ram_en, ram_we;
  logic [AW-1:0]         ram_addr;
  logic [AHB_DWIDTH-1:0] ram_rdata;

  // Address-phase decode
  logic [AW-1:0] word_idx;
  logic          out_of_range, illegal, take, hready;
  logic [7:0]    strb_full;

  assign word_idx     = HADDR[BL+AW-1:BL];
  assign out_of_range = |HADDR[AHB_AWIDTH-1:BL+AW];
  assign illegal      = (HSIZE > 3'(BL)) || ((HADDR[2:0] & align_mask(HSIZE)) != 3'b000);
  assign strb_full    = byte_strobe(HSIZE, HADDR[2:0] & LSB_MASK);

  assign hready = !((state_q == ERR1) || ((state_q == RWAIT) && (cnt_q != 3'd0)));
  assign take   = HSEL && HREADYIN && hready &&
                  ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_pend_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_strb_d = wr_strb_q;
    rd_hz_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_dph_d  = rd_dph_q;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = word_idx;
    HREADYOUT = hready;
    HRESP     = ((state_q == ERR1) || (state_q == ERR2)) ? HRESP_ERROR : HRESP_OKAY;

    // Data-phase RAM traffic: a write commits now, or a deferred read goes out.
    if (wr_pend_q) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = wr_addr_q;
    end else if (rd_hz_q) begin
      ram_en   = 1'b1;
      ram_addr = rd_addr_q;
    end

    case (state_q)
      RWAIT: begin
        if (cnt_q != 3'd0) cnt_d   = cnt_q - 3'd1;
        else               state_d = IDLE;
      end
      ERR1:    state_d = ERR2;
      ERR2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (hready) rd_dph_d = 1'b0;

    if (take) begin
      cnt_d = 3'd0;
      if (out_of_range || illegal) begin
        state_d = ERR1;
      end else if (HWRITE) begin
        wr_pend_d = 1'b1;
        wr_addr_d = word_idx;
        wr_strb_d = strb_full[NB-1:0];
        state_d   = IDLE;
      end else begin
        rd_dph_d = 1'b1;
        if (wr_pend_q) begin
          // Port busy with the previous write: defer the read one cycle.
          rd_hz_d   = 1'b1;
          rd_addr_d = word_idx;
          cnt_d     = 3'(WAIT_STATES) + 3'd1;
          state_d   = RWAIT;
        end else begin
          ram_en  = 1'b1;
          cnt_d   = 3'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? RWAIT : IDLE;
        end
      end
    end

    if (!HRESETN) ram_en = 1'b0;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      wr_pend_q <= 1'b0;
      wr_addr_q <= '0;
      wr_strb_q <= '0;
      rd_hz_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_dph_q  <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_pend_q <= wr_pend_d;
      wr_addr_q <= wr_addr_d;
      wr_strb_q <= wr_strb_d;
      rd_hz_q   <= rd_hz_d;
      rd_addr_q <= rd_addr_d;
      rd_dph_q  <= rd_dph_d;
      hold_q    <= HRDATA;
    end
  end

  assign HRDATA = rd_dph_q ? ram_rdata : hold_q;

  sram_bank #(
    .DWIDTH(AHB_DWIDTH),
    .DEPTH (DEPTH)
  ) u_bank (
    .clk_i  (HCLK),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .be_i   (wr_strb_q),
    .addr_i (ram_addr),
    .wdata_i(HWDATA),
    .rdata_o(ram_rdata)
  );

  logic unused_ok;
  assign unused_ok = ^{HBURST, strb_full};

endmodule

// File: tb/tb_ahbl_sram_ws.sv
module tb_ahbl_sram_ws;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, hsel, use_b, hwrite, hreadyin;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [31:0] haddr;
  logic [63:0] hwdata;
  logic        a_rdy, b_rdy;
  logic [1:0]  a_resp, b_resp;
  logic [31:0] a_rdata;
  logic [63:0] b_rdata;

  assign hreadyin = use_b ? b_rdy : a_rdy;

  // A: 32-bit, 1024 words, zero wait. B: 64-bit, 256 words, two wait states.
  ahbl_sram_ws #(.AHB_AWIDTH(32), .AHB_DWIDTH(32), .DEPTH(1024), .WAIT_STATES(0)) u_a (
    .HCLK(clk), .HRESETN(rstn), .HSEL(hsel & ~use_b), .HREADYIN(hreadyin),
    .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HWRITE(hwrite),
    .HWDATA(hwdata[31:0]), .HRDATA(a_rdata), .HREADYOUT(a_rdy), .HRESP(a_resp));

  ahbl_sram_ws #(.AHB_AWIDTH(32), .AHB_DWIDTH(64), .DEPTH(256), .WAIT_STATES(2)) u_b (
    .HCLK(clk), .HRESETN(rstn), .HSEL(hsel & use_b), .HREADYIN(hreadyin),
    .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HWRITE(hwrite),
    .HWDATA(hwdata), .HRDATA(b_rdata), .HREADYOUT(b_rdy), .HRESP(b_resp));

  localparam logic [1:0] T_ID = 2'b00, T_BZ = 2'b01, T_NS = 2'b10;
  localparam logic [1:0] OK = 2'b00, ER = 2'b01;

  // One record per clock: bus inputs for that cycle and outputs expected in it.
  typedef struct {
    logic        b;
    logic        rstn;
    logic        sel;
    logic [1:0]  tr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [63:0] wd;
    logic        rdy;
    logic [1:0]  rsp;
    logic        chk;
    logic [63:0] d;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic b, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                     input logic [31:0] a, input logic [63:0] wd, input logic rdy,
                     input logic [1:0] rsp, input logic chk, input logic [63:0] d);
    vec_t v;
    v.b = b; v.rstn = 1'b1; v.sel = 1'b1; v.tr = tr; v.wr = wr; v.sz = sz; v.a = a;
    v.wd = wd; v.rdy = rdy; v.rsp = rsp; v.chk = chk; v.d = d;
    tbl.push_back(v);
  endtask

  task automatic last_rstn_low();
    int n;
    n = tbl.size() - 1;
    tbl[n].rstn = 1'b0;
  endtask

  task automatic last_unselected();
    int n;
    n = tbl.size() - 1;
    tbl[n].sel = 1'b0;
  endtask

  task automatic idle(input logic b, input logic rdy, input logic [1:0] rsp,
                      input logic chk, input logic [63:0] d);
    add(b, T_ID, 1'b0, 3'd0, 32'h0, 64'h0, rdy, rsp, chk, d);
  endtask

  task automatic check(input string what, input int idx, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL vec%0d %s got %h want %h", idx, what, got, exp);
    end
  endtask

  initial begin
    rstn = 1'b0; hsel = 1'b0; use_b = 1'b0; htrans = T_ID; hwrite = 1'b0;
    hsize = 3'd0; haddr = 32'h0; hwdata = 64'h0; hburst = 3'd0;

    // ---- Instance A: hazard read after write ----
    add(0, T_NS, 1'b1, 3'd2, 32'h10, 64'h0, 1'b1, OK, 1'b0, 64'h0);
    add(0, T_NS, 1'b0, 3'd2, 32'h10, 64'hDEADBEEF, 1'b1, OK, 1'b0, 64'h0);
    idle(0, 1'b0, OK, 1'b0, 64'h0);
    idle(0, 1'b1, OK, 1'b1, 64'hDEADBEEF);
    // ---- byte / halfword strobes ----
    add(0, T_NS, 1'b1, 3'd2, 32'h10, 64'h0, 1'b1, OK, 1'b0, 64'h0);
    add(0, T_NS, 1'b1, 3'd0, 32'h13, 64'h0, 1'b1, OK, 1'b0, 64'h0);
    add(0, T_NS, 1'b1, 3'd1, 32'h10, 64'hAA000000, 1'b1, OK, 1'b0, 64'h0);
    add(0, T_ID, 1'b0, 3'd0, 32'h0, 64'h00005566, 1'b1, OK, 1'b0, 64'h0);
    add(0, T_NS, 1'b0, 3'd2, 32'h10, 64'h0, 1'b1, OK, 1'b0, 64'h0);
    idle(0, 1'b1, OK, 1'b1, 64'hAA005566);
    // ---- back-to-back zero-wait reads ----
    add(0, T_NS, 1'b1, 3'd2, 32'h14, 64'h0, 1'b1, OK, 1'b0, 64'h0);
    add(0, T_ID, 1'b0, 3'd0, 32'h0, 64'h12345678, 1'b1, OK, 1'b0, 64'h0);
    add(0, T_NS, 1'b0, 3'd2, 32'h10, 64'h0, 1'b1, OK, 1'b0, 64'h0);
    add(0, T_NS, 1'b0, 3'd2, 32'h14, 64'h0, 1'b1, OK, 1'b1, 64'hAA005566);
    idle(0, 1'b1, OK, 1'b1, 64'h12345678);
    // ---- out-of-range write (would alias 0x10) and read, then a good read ----
    add(0, T_NS, 1'b1, 3'd2, 32'h1010, 64'h0, 1'b1, OK, 1'b0, 64'h0);
    add(0, T_ID, 1'b0, 3'd0, 32'h0, 64'hFFFFFFFF, 1'b0, ER, 1'b0, 64'h0);
    add(0, T_NS, 1'b0, 3'd2, 32'h1000, 64'hFFFFFFFF, 1'b1, ER, 1'b0, 64'h0);
    idle(0, 1'b0, ER, 1'b0, 64'h0);
    add(0, T_NS, 1'b0, 3'd2, 32'h10, 64'h0, 1'b1, ER, 1'b0, 64'h0);
    idle(0, 1'b1, OK, 1'b1, 64'hAA005566);
    // ---- misaligned halfword write; read held through ERR1 ----
    add(0, T_NS, 1'b1, 3'd1, 32'h11, 64'h0, 1'b1, OK, 1'b0, 64'h0);
    add(0, T_NS, 1'b0, 3'd2, 32'h10, 64'hFFFFFFFF, 1'b0, ER, 1'b0, 64'h0);
    add(0, T_NS, 1'b0, 3'd2, 32'h10, 64'hFFFFFFFF, 1'b1, ER, 1'b0, 64'h0);
    idle(0, 1'b1, OK, 1'b1, 64'hAA005566);
    // ---- oversize transfer right after a write: no stall, write commits ----
    add(0, T_NS, 1'b1, 3'd2, 32'h18, 64'h0, 1'b1, OK, 1'b0, 64'h0);
    add(0, T_NS, 1'b0, 3'd3, 32'h18, 64'hCAFEF00D, 1'b1, OK, 1'b0, 64'h0);
    idle(0, 1'b0, ER, 1'b0, 64'h0);
    add(0, T_NS, 1'b0, 3'd2, 32'h18, 64'h0, 1'b1, ER, 1'b0, 64'h0);
    idle(0, 1'b1, OK, 1'b1, 64'hCAFEF00D);
    // ---- unselected and BUSY cycles are ignored ----
    add(0, T_NS, 1'b1, 3'd2, 32'h10, 64'h0, 1'b1, OK, 1'b0, 64'h0);
    last_unselected();
    add(0, T_BZ, 1'b1, 3'd2, 32'h10, 64'h0, 1'b1, OK, 1'b0, 64'h0);
    add(0, T_NS, 1'b0, 3'd2, 32'h10, 64'h0, 1'b1, OK, 1'b0, 64'h0);
    idle(0, 1'b1, OK, 1'b1, 64'hAA005566);
    // ---- reset during a write data phase ----
    add(0, T_NS, 1'b1, 3'd2, 32'h20, 64'h0, 1'b1, OK, 1'b0, 64'h0);
    add(0, T_NS, 1'b0, 3'd2, 32'h20, 64'h01234567, 1'b1, OK, 1'b0, 64'h0);
    idle(0, 1'b0, OK, 1'b0, 64'h0);
    idle(0, 1'b1, OK, 1'b1, 64'h01234567);
    add(0, T_NS, 1'b1, 3'd2, 32'h20, 64'h0, 1'b1, OK, 1'b1, 64'h01234567);
    add(0, T_ID, 1'b0, 3'd0, 32'h0, 64'h55AA55AA, 1'b1, OK, 1'b0, 64'h0);
    last_rstn_low();
    idle(0, 1'b1, OK, 1'b1, 64'h0);
    add(0, T_NS, 1'b0, 3'd2, 32'h20, 64'h0, 1'b1, OK, 1'b0, 64'h0);
    idle(0, 1'b1, OK, 1'b1, 64'h01234567);
    // ---- reset during ERR1 returns straight to OKAY/ready ----
    add(0, T_NS, 1'b1, 3'd1, 32'h21, 64'h0, 1'b1, OK, 1'b0, 64'h0);
    idle(0, 1'b0, ER, 1'b0, 64'h0);
    last_rstn_low();
    idle(0, 1'b1, OK, 1'b0, 64'h0);

    // ---- Instance B: doubleword and word-lane writes ----
    add(1, T_NS, 1'b1, 3'd3, 32'h8, 64'h0, 1'b1, OK, 1'b0, 64'h0);
    add(1, T_ID, 1'b0, 3'd0, 32'h0, 64'h1122334455667788, 1'b1, OK, 1'b0, 64'h0);
    add(1, T_NS, 1'b1, 3'd3, 32'h0, 64'h0, 1'b1, OK, 1'b0, 64'h0);
    add(1, T_NS, 1'b1, 3'd2, 32'h4, 64'hA0A0A0A0B0B0B0B0, 1'b1, OK, 1'b0, 64'h0);
    add(1, T_ID, 1'b0, 3'd0, 32'h0, 64'hC0C0C0C000000000, 1'b1, OK, 1'b0, 64'h0);
    // ---- back-to-back reads, two wait states each ----
    add(1, T_NS, 1'b0, 3'd3, 32'h0, 64'h0, 1'b1, OK, 1'b0, 64'h0);
    add(1, T_NS, 1'b0, 3'd3, 32'h8, 64'h0, 1'b0, OK, 1'b0, 64'h0);
    add(1, T_NS, 1'b0, 3'd3, 32'h8, 64'h0, 1'b0, OK, 1'b0, 64'h0);
    add(1, T_NS, 1'b0, 3'd3, 32'h8, 64'h0, 1'b1, OK, 1'b1, 64'hC0C0C0C0B0B0B0B0);
    idle(1, 1'b0, OK, 1'b0, 64'h0);
    idle(1, 1'b0, OK, 1'b0, 64'h0);
    idle(1, 1'b1, OK, 1'b1, 64'h1122334455667788);
    // ---- hazard with wait states: 2 + 1 stall cycles ----
    add(1, T_NS, 1'b1, 3'd3, 32'h10, 64'h0, 1'b1, OK, 1'b0, 64'h0);
    add(1, T_NS, 1'b0, 3'd3, 32'h10, 64'h0F0E0D0C0B0A0908, 1'b1, OK, 1'b0, 64'h0);
    idle(1, 1'b0, OK, 1'b0, 64'h0);
    idle(1, 1'b0, OK, 1'b0, 64'h0);
    idle(1, 1'b0, OK, 1'b0, 64'h0);
    idle(1, 1'b1, OK, 1'b1, 64'h0F0E0D0C0B0A0908);
    // ---- HSIZE above bus width: error, no write ----
    add(1, T_NS, 1'b1, 3'd4, 32'h0, 64'h0, 1'b1, OK, 1'b0, 64'h0);
    add(1, T_ID, 1'b0, 3'd0, 32'h0, 64'hFFFFFFFFFFFFFFFF, 1'b0, ER, 1'b0, 64'h0);
    add(1, T_NS, 1'b0, 3'd3, 32'h0, 64'h0, 1'b1, ER, 1'b0, 64'h0);
    idle(1, 1'b0, OK, 1'b0, 64'h0);
    idle(1, 1'b0, OK, 1'b0, 64'h0);
    idle(1, 1'b1, OK, 1'b1, 64'hC0C0C0C0B0B0B0B0);

    // Reset state of both instances
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_hreadyout", -1, {63'h0, a_rdy}, 64'h1);
    check("rst_a_hresp", -1, {62'h0, a_resp}, {62'h0, OK});
    check("rst_a_hrdata", -1, {32'h0, a_rdata}, 64'h0);
    check("rst_b_hreadyout", -1, {63'h0, b_rdy}, 64'h1);
    check("rst_b_hresp", -1, {62'h0, b_resp}, {62'h0, OK});
    check("rst_b_hrdata", -1, b_rdata, 64'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      logic        g_rdy;
      logic [1:0]  g_rsp;
      logic [63:0] g_d;
      @(posedge clk);
      #1;
      use_b  = tbl[i].b;
      rstn   = tbl[i].rstn;
      hsel   = tbl[i].sel;
      htrans = tbl[i].tr;
      hwrite = tbl[i].wr;
      hsize  = tbl[i].sz;
      haddr  = tbl[i].a;
      hwdata = tbl[i].wd;
      @(negedge clk);
      g_rdy = tbl[i].b ? b_rdy : a_rdy;
      g_rsp = tbl[i].b ? b_resp : a_resp;
      g_d   = tbl[i].b ? b_rdata : {32'h0, a_rdata};
      check("hreadyout", i, {63'h0, g_rdy}, {63'h0, tbl[i].rdy});
      check("hresp", i, {62'h0, g_rsp}, {62'h0, tbl[i].rsp});
      if (tbl[i].chk) check("hrdata", i, g_d, tbl[i].d);
    end

    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
